multicore_run_ctrl: RTL

//  Parametrised run controller for an N-core multicore array. It sequences a core reset

---
 rtl/multicore_run_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/multicore_run_ctrl.sv
// Run controller for an N-core array.
// Pulses the core reset and enables the cores.
// Latches each core's end-of-program flag together with its final bus value and Z flag.
// Counts run cycles and finishes in DONE (all cores ended) or TMO (watchdog expired).
module multicore_run_ctrl #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_W     = 24,
  parameter int CYC_W      = 32,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                          clk2,
  input  logic                          controlRST,
  input  logic                          clock_en,
  input  logic [NUM_CORES-1:0]          core_endp,
  input  logic [NUM_CORES-1:0]          core_zout,
  input  logic [NUM_CORES*DATA_W-1:0]   core_bus,
  input  logic [3:0]                    rd_sel,
  output logic                          core_rst,
  output logic [NUM_CORES-1:0]          core_en,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout,
  output logic [NUM_CORES-1:0]          end_mask,
  output logic [CYC_W-1:0]              cycle_count,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_z
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE,
    S_TMO
  } state_e;

  localparam int             RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TMO_VAL = CYC_W'(TIMEOUT);

  state_e                            state_q, state_d;
  logic                              en_q;
  logic [RCW-1:0]                    rst_cnt_q, rst_cnt_d;
  logic                              core_rst_q, core_rst_d;
  logic [NUM_CORES-1:0]              core_en_q, core_en_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic                              timeout_q, timeout_d;
  logic [NUM_CORES-1:0]              end_mask_q, end_mask_d;
  logic [CYC_W-1:0]                  cycle_count_q, cycle_count_d;
  logic [NUM_CORES-1:0][DATA_W-1:0]  res_q, res_d;
  logic [NUM_CORES-1:0]              zr_q, zr_d;

  logic                              start;
  logic [NUM_CORES-1:0]              new_end;
  logic [CYC_W-1:0]                  cnt_inc;

  assign start   = clock_en & ~en_q;
  assign cnt_inc = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CYC_W'(1);

  // Register every piece of state; synchronous reset wins over everything.
  always_ff @(posedge clk2) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (controlRST) begin
      state_q       <= S_IDLE;
      // The run-request copy tracks the input even in reset, so a request that is already
      // high when reset releases is not mistaken for a rising edge.
      en_q          <= clock_en;
      rst_cnt_q     <= '0;
      core_rst_q    <= 1'b0;
      core_en_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      end_mask_q    <= '0;
      cycle_count_q <= '0;
      // NOTE: the capture arrays are reset as well, so a read after reset returns zeros
      // rather than the results of an aborted run.
      res_q         <= '0;
      zr_q          <= '0;
    end else begin
      state_q       <= state_d;
      en_q          <= clock_en;
      rst_cnt_q     <= rst_cnt_d;
      core_rst_q    <= core_rst_d;
      core_en_q     <= core_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      end_mask_q    <= end_mask_d;
      cycle_count_q <= cycle_count_d;
      res_q         <= res_d;
      zr_q          <= zr_d;
    end
  end

  // Next-state and registered-output logic for the run sequence.
  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    core_rst_d    = core_rst_q;
    core_en_d     = core_en_q;
    busy_d        = busy_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    end_mask_d    = end_mask_q;
    cycle_count_d = cycle_count_q;
    res_d         = res_q;
    zr_d          = zr_q;
    new_end       = '0;

    case (state_q)
      S_IDLE: begin
        core_rst_d = 1'b0;
        core_en_d  = '0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        if (start) begin
          state_d       = S_RESET;
          core_rst_d    = 1'b1;
          busy_d        = 1'b1;
          rst_cnt_d     = '0;
          end_mask_d    = '0;
          cycle_count_d = '0;
          res_d         = '0;
          zr_d          = '0;
        end
      end

      S_RESET: begin
        core_en_d = '0;
        if (rst_cnt_q == RST_LAST) begin
          state_d    = S_RUN;
          core_rst_d = 1'b0;
          core_en_d  = {NUM_CORES{clock_en}};
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end

      S_RUN: begin
        // Only the first end-of-program pulse of each core is captured.
        new_end    = core_endp & ~end_mask_q;
        end_mask_d = end_mask_q | new_end;
        for (int i = 0; i < NUM_CORES; i++) begin
          if (new_end[i]) begin
            res_d[i] = core_bus[i*DATA_W +: DATA_W];
            zr_d[i]  = core_zout[i];
          end
        end
        if (clock_en) begin
          cycle_count_d = cnt_inc;
        end
        core_en_d = {NUM_CORES{clock_en}} & ~end_mask_d;
        // Completion outranks the watchdog when both occur on the same cycle.
        if (&end_mask_d) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          core_en_d = '0;
        end else if ((TIMEOUT != 0) && clock_en && (cnt_inc == TMO_VAL)) begin
          state_d   = S_TMO;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          core_en_d = '0;
        end
      end

      S_DONE, S_TMO: begin
        core_en_d = '0;
        if (!clock_en) begin
          state_d   = S_IDLE;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Combinational readback of the captured results; out-of-range indices read zero.
  always_comb begin
    rd_data = '0;
    rd_z    = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (rd_sel == 4'(i)) begin
        rd_data = res_q[i];
        rd_z    = zr_q[i];
      end
    end
  end

  assign core_rst    = core_rst_q;
  assign core_en     = core_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign end_mask    = end_mask_q;
  assign cycle_count = cycle_count_q;

endmodule
